// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with one-entry holding buffer                |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uartRxPin,
  input  logic       re,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       overrun,
  output logic       frame_error,
  output logic       busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] c_S_IDLE      = 3'd0;
  localparam logic [2:0] c_S_START     = 3'd1;
  localparam logic [2:0] c_S_DATA      = 3'd2;
  localparam logic [2:0] c_S_STOP      = 3'd3;
  localparam logic [2:0] c_S_WAIT_HIGH = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_sync1;
  logic               r_rx_s;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bitidx;
  logic [7:0]         r_shift;
  logic               r_commit;
  logic [7:0]         r_rdata;
  logic               r_rvalid;
  logic               r_overrun;
  logic               r_frame_error;
  logic               r_busy;

  logic [c_CNT_W-1:0] w_limit;
  logic               w_last;
  logic               w_timing;
  logic               w_shift;
  logic               w_commit;
  logic               w_ferr;

  // State register; busy tracks the state it is registered with
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != c_S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:      if (!r_rx_s) w_state_nxt = c_S_START;
      c_S_START:     if (w_last) w_state_nxt = r_rx_s ? c_S_IDLE : c_S_DATA;
      c_S_DATA:      if (w_last && (r_bitidx == 3'd7)) w_state_nxt = c_S_STOP;
      c_S_STOP:      if (w_last) w_state_nxt = r_rx_s ? c_S_IDLE : c_S_WAIT_HIGH;
      c_S_WAIT_HIGH: if (r_rx_s) w_state_nxt = c_S_IDLE;
      default:       w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_limit  = (r_state == c_S_START) ? c_HALF_LAST : c_FULL_LAST;
    w_last   = (r_cnt == w_limit);
    w_timing = (r_state == c_S_START) || (r_state == c_S_DATA) || (r_state == c_S_STOP);
    w_shift  = (r_state == c_S_DATA) && w_last;
    w_commit = (r_state == c_S_STOP) && w_last && r_rx_s;
    w_ferr   = (r_state == c_S_STOP) && w_last && !r_rx_s;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1       <= 1'b1;
      r_rx_s        <= 1'b1;
      r_cnt         <= '0;
      r_bitidx      <= 3'd0;
      r_shift       <= 8'd0;
      r_commit      <= 1'b0;
      r_rdata       <= 8'd0;
      r_rvalid      <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_sync1 <= uartRxPin;
      r_rx_s  <= r_sync1;

      if (!w_timing || w_last || (w_state_nxt != r_state))
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;

      if (r_state == c_S_START)
        r_bitidx <= 3'd0;
      else if (w_shift)
        r_bitidx <= (r_bitidx == 3'd7) ? 3'd0 : r_bitidx + 3'd1;

      if (w_shift)
        r_shift <= {r_rx_s, r_shift[7:1]};

      r_commit      <= w_commit;
      r_frame_error <= w_ferr;

      // An acknowledge coinciding with a commit consumes the old byte, not the new one
      if (r_commit) begin
        r_rdata  <= r_shift;
        r_rvalid <= 1'b1;
        if (re)
          r_overrun <= 1'b0;
        else if (r_rvalid)
          r_overrun <= 1'b1;
      end else if (re && r_rvalid) begin
        r_rvalid  <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign rdata       = r_rdata;
  assign rvalid      = r_rvalid;
  assign overrun     = r_overrun;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule
`default_nettype wire
